// File: rtl/disp_owner_sched_if.sv
// Bus bundle between the display-ownership scheduler and its sources/multiplexer.
// The master drives the source A/B data, the request and alarm; the slave (scheduler) drives the rest.
interface disp_owner_sched_if;
  logic [6:0] a_d0, a_d1, a_d2, a_d3;
  logic [6:0] b_d0, b_d1, b_d2, b_d3;
  logic       b_req;
  logic       b_ack;
  logic       b_done;
  logic       alarm;
  logic [6:0] d0, d1, d2, d3;
  logic       owner;

  modport master (
    output a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3, b_req, alarm,
    input  b_ack, b_done, d0, d1, d2, d3, owner
  );

  modport slave (
    input  a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3, b_req, alarm,
    output b_ack, b_done, d0, d1, d2, d3, owner
  );
endinterface

// File: rtl/disp_owner_sched.sv
// Display ownership scheduler: source A by default, source B granted for a fixed hold then a guard.
// Optional alarm blink of all digits is enabled by defining DISP_ALARM_BLINK_EN.
module disp_owner_sched #(
  parameter int TICK_DIV = 50000,
  parameter int TICK_W   = 16,
  parameter int HOLD_MS  = 2000,
  parameter int GUARD_MS = 500,
  parameter int BLINK_MS = 250,
  parameter int MS_W     = 12
) (
  input  logic                clk,
  input  logic                reset,
  disp_owner_sched_if.slave   bus
);

  typedef enum logic [1:0] {SHOW_A, GRANT_B, SHOW_B, GUARD} state_t;

  localparam int HOLD_N  = (HOLD_MS  == 0) ? 1 : HOLD_MS;
  localparam int GUARD_N = (GUARD_MS == 0) ? 1 : GUARD_MS;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   HOLD_LAST  = MS_W'(HOLD_N - 1);
  localparam logic [MS_W-1:0]   GUARD_LAST = MS_W'(GUARD_N - 1);

  state_t            state;
  logic [TICK_W-1:0] presc;
  logic [MS_W-1:0]   ms_cnt;
  logic [3:0][6:0]   a_vec, b_vec, b_lat, disp_q;
  logic              owner_q, b_ack_q, b_done_q;
  logic              tick;
  logic              blank;

  assign a_vec = {bus.a_d3, bus.a_d2, bus.a_d1, bus.a_d0};
  assign b_vec = {bus.b_d3, bus.b_d2, bus.b_d1, bus.b_d0};
  assign tick  = (presc == TICK_LAST);

`ifdef DISP_ALARM_BLINK_EN
  localparam int                BLINK_N    = (BLINK_MS == 0) ? 1 : BLINK_MS;
  localparam logic [MS_W-1:0]   BLINK_LAST = MS_W'(BLINK_N - 1);

  logic [MS_W-1:0] blink_cnt;
  logic            phase;

  // Free-running: follows the shared ms tick regardless of ownership state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + MS_W'(1);
      end
    end
  end

  assign blank = bus.alarm & phase;
`else
  logic [MS_W:0] unused_blink_cfg;
  assign unused_blink_cfg = {bus.alarm, MS_W'(BLINK_MS)};
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SHOW_A;
      presc    <= '0;
      ms_cnt   <= '0;
      // NOTE: the B latch is reset like every other register so a post-reset SHOW_B can never expose stale data.
      b_lat    <= '1;
      disp_q   <= '1;
      owner_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      // NOTE: pulses default low here; a later assignment in the case below wins for that one cycle.
      b_ack_q  <= 1'b0;
      b_done_q <= 1'b0;
      presc    <= tick ? '0 : presc + TICK_W'(1);

      case (state)
        SHOW_A: begin
          disp_q  <= a_vec;
          owner_q <= 1'b0;
          if (bus.b_req) begin
            state   <= GRANT_B;
            b_lat   <= b_vec;
            b_ack_q <= 1'b1;
          end
        end
        GRANT_B: begin
          state   <= SHOW_B;
          disp_q  <= b_lat;
          owner_q <= 1'b1;
          presc   <= '0;
          ms_cnt  <= '0;
        end
        SHOW_B: begin
          disp_q <= b_lat;
          if (tick) begin
            if (ms_cnt == HOLD_LAST) begin
              state    <= GUARD;
              disp_q   <= a_vec;
              owner_q  <= 1'b0;
              b_done_q <= 1'b1;
              presc    <= '0;
              ms_cnt   <= '0;
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
        end
        GUARD: begin
          disp_q  <= a_vec;
          owner_q <= 1'b0;
          if (tick) begin
            if (ms_cnt == GUARD_LAST) begin
              state  <= SHOW_A;
              ms_cnt <= '0;
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
        end
        default: state <= SHOW_A;
      endcase

      // Blanking overrides only the digits; state, owner and pulses keep their timing.
      if (blank) disp_q <= '1;
    end
  end

  assign bus.d0     = disp_q[0];
  assign bus.d1     = disp_q[1];
  assign bus.d2     = disp_q[2];
  assign bus.d3     = disp_q[3];
  assign bus.owner  = owner_q;
  assign bus.b_ack  = b_ack_q;
  assign bus.b_done = b_done_q;

endmodule

// File: tb/tb_disp_owner_sched.sv
// Scoreboard bench for disp_owner_sched: stimulus queues expected samples/pulses, a monitor compares.
// Cycle N is the period after the N-th rising edge since reset release.
module tb_disp_owner_sched;

  localparam logic [27:0] BLANK = 28'hFFFFFFF;
  localparam logic [27:0] A1 = {7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [27:0] A2 = {7'h00, 7'h78, 7'h02, 7'h12};
  localparam logic [27:0] M1 = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] M2 = {7'h6F, 7'h07, 7'h7D, 7'h6D};
  localparam logic [27:0] M3 = {7'h77, 7'h38, 7'h79, 7'h71};
  localparam logic [27:0] M4 = {7'h74, 7'h54, 7'h1C, 7'h5E};

  typedef struct {
    int          cyc;
    logic [27:0] dv;
    logic        owner;
  } sample_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  sample_t samp_q[$];
  int      ack_q[$];
  int      done_q[$];

  disp_owner_sched_if bus();

  disp_owner_sched #(
    .TICK_DIV(4), .TICK_W(3), .HOLD_MS(3), .GUARD_MS(2), .BLINK_MS(2), .MS_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_samp(input int c, input logic [27:0] dv, input logic own);
    sample_t s;
    s.cyc = c; s.dv = dv; s.owner = own;
    samp_q.push_back(s);
  endtask

  task automatic set_a(input logic [27:0] v);
    bus.a_d0 = v[6:0]; bus.a_d1 = v[13:7]; bus.a_d2 = v[20:14]; bus.a_d3 = v[27:21];
  endtask

  task automatic set_b(input logic [27:0] v);
    bus.b_d0 = v[6:0]; bus.b_d1 = v[13:7]; bus.b_d2 = v[20:14]; bus.b_d3 = v[27:21];
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compares due samples and every pulse the DUT presents against the queues.
  always @(negedge clk) begin
    sample_t e;
    int      ec;
    while (samp_q.size() > 0 && samp_q[0].cyc <= cyc) begin
      e = samp_q.pop_front();
      check($sformatf("digits_c%0d", e.cyc), {4'h0, bus.d3, bus.d2, bus.d1, bus.d0}, {4'h0, e.dv});
      check($sformatf("owner_c%0d", e.cyc), {31'd0, bus.owner}, {31'd0, e.owner});
    end
    if (bus.b_ack === 1'b1) begin
      if (ack_q.size() == 0) check($sformatf("unexpected_ack_c%0d", cyc), {31'd0, bus.b_ack}, 32'd0);
      else begin
        ec = ack_q.pop_front();
        check("ack_cycle", cyc, ec);
      end
    end
    if (bus.b_done === 1'b1) begin
      if (done_q.size() == 0) check($sformatf("unexpected_done_c%0d", cyc), {31'd0, bus.b_done}, 32'd0);
      else begin
        ec = done_q.pop_front();
        check("done_cycle", cyc, ec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blanks;
    reset = 1'b1;
    set_a(A1);
    set_b(M1);
    bus.b_req = 1'b0;
    bus.alarm = 1'b0;
    push_samp(0, BLANK, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Epoch 1: grant, held request with guard, frozen data with mid-hold drop, then reset mid-hold.
    push_samp(1, A1, 1'b0);
    push_samp(5, A1, 1'b0);
    push_samp(10, A1, 1'b0);
    ack_q.push_back(11);
    push_samp(11, A1, 1'b0);
    push_samp(12, M1, 1'b1);
    push_samp(17, M1, 1'b1);
    push_samp(23, M1, 1'b1);
    done_q.push_back(24);
    push_samp(24, A1, 1'b0);
    push_samp(31, A1, 1'b0);
    push_samp(32, A1, 1'b0);
    ack_q.push_back(33);
    push_samp(33, A1, 1'b0);
    push_samp(34, M2, 1'b1);
    push_samp(37, M2, 1'b1);
    push_samp(40, M2, 1'b1);
    push_samp(43, M2, 1'b1);
    push_samp(45, M2, 1'b1);
    done_q.push_back(46);
    push_samp(46, A2, 1'b0);
    push_samp(53, A2, 1'b0);
    push_samp(54, A2, 1'b0);
    push_samp(58, A2, 1'b0);
    ack_q.push_back(61);
    push_samp(62, M4, 1'b1);
    push_samp(65, M4, 1'b1);

    wait_cyc(10); bus.b_req = 1'b1;
    wait_cyc(28); set_b(M2);
    wait_cyc(36); set_b(M3);
    wait_cyc(38); bus.b_req = 1'b0;
    wait_cyc(42); set_a(A2);
    wait_cyc(60); bus.b_req = 1'b1; set_b(M4);
    wait_cyc(66);
    #2;
    reset = 1'b1;
    bus.b_req = 1'b0;
    set_b(M1);
    push_samp(0, BLANK, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Epoch 2: normal grant after the aborted hold, then alarm held high in SHOW_A.
    push_samp(1, A2, 1'b0);
    push_samp(4, A2, 1'b0);
    ack_q.push_back(6);
    push_samp(7, M1, 1'b1);
    push_samp(18, M1, 1'b1);
    done_q.push_back(19);
    push_samp(19, A2, 1'b0);
`ifndef DISP_ALARM_BLINK_EN
    for (int i = 32; i < 48; i++) push_samp(i, A2, 1'b0);
`endif

    wait_cyc(5); bus.b_req = 1'b1;
    wait_cyc(8); bus.b_req = 1'b0;
    wait_cyc(28); bus.alarm = 1'b1;
`ifdef DISP_ALARM_BLINK_EN
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      wait_cyc(32 + i);
      if ({bus.d3, bus.d2, bus.d1, bus.d0} === BLANK) blanks++;
    end
    check("blink_blank_cycles", blanks, 16);
`else
    blanks = 0;
`endif
    wait_cyc(64);
    bus.alarm = 1'b0;
    repeat (4) @(negedge clk);

    check("samples_pending", samp_q.size(), 0);
    check("acks_pending", ack_q.size(), 0);
    check("dones_pending", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_owner_sched.md
Name: disp_owner_sched

Overview:
- Controller placed ahead of the 4-digit seven-segment multiplexer.
- Decides which source owns the display:
  - source A: continuous readout, always available.
  - source B: event/message source using a req/ack handshake.
- Grants B for a fixed hold time, then enforces a guard interval of A ownership so A is never starved.
- Drives four registered 7-bit active-low digit patterns (blank = 7'b1111111) and an ownership flag into the multiplexer.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clk); minimum 2.
- TICK_W, 16, prescaler width; must satisfy 2^TICK_W > TICK_DIV.
- HOLD_MS, 2000, ms ticks B owns the display per grant; value 0 is treated as 1.
- GUARD_MS, 500, ms ticks A keeps the display after a B release before B can be granted again; value 0 is treated as 1.
- BLINK_MS, 250, ms ticks per blink half-period (optional feature only).
- MS_W, 12, width of the ms counters; 2^MS_W must exceed max(HOLD_MS, GUARD_MS, BLINK_MS).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a_d0, a_d1, a_d2, a_d3  in  7 each  source A digit patterns, active-low
- b_req  in  1  B request level; held high until b_ack
- b_d0, b_d1, b_d2, b_d3  in  7 each  B digit patterns; must be valid while b_req=1
- b_ack  out  1  one-cycle grant pulse
- b_done  out  1  one-cycle pulse when the B hold expires
- alarm  in  1  level; blink request (used only with the optional feature)
- d0, d1, d2, d3  out  7 each  digit patterns to the multiplexer
- owner  out  1  0 = A owns display, 1 = B owns display

Behaviour:
- Reset values (async, all registers):
  - state = SHOW_A; prescaler = 0; ms counters = 0.
  - d0..d3 = 7'b1111111; owner = 0; b_ack = 0; b_done = 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 on the cycle count = TICK_DIV-1. Forced to 0 on entry to SHOW_B and on entry to GUARD, so interval lengths are exact.
- Timing: all outputs are registered and change on the same edge as the state register.
- SHOW_A:
  - owner = 0; d* <= a_d* every cycle (one-cycle latency).
  - If b_req = 1: go to GRANT_B; latch b_d* on that edge.
- GRANT_B (exactly 1 cycle):
  - b_ack = 1; d* keep following a_d*.
  - Next state: SHOW_B.
- SHOW_B:
  - owner = 1; d* = latched B data, frozen (b_d* changes are ignored).
  - Lasts exactly HOLD_MS*TICK_DIV cycles.
  - On the last cycle, go to GUARD. On that edge b_done <= 1 for one cycle and owner <= 0.
- GUARD:
  - owner = 0; d* follow a_d*.
  - b_req is ignored and stays pending with no ack.
  - Lasts exactly GUARD_MS*TICK_DIV cycles, then go to SHOW_A. A pending b_req is granted on the next edge.
- b_req deasserted before being sampled in SHOW_A: no grant. Deassertion during GRANT_B, SHOW_B or GUARD has no effect; the hold always completes.
- Reset mid-operation (any state): immediate return to reset values. No b_done is issued for the aborted hold.

Optional Feature:
- Macro: DISP_ALARM_BLINK_EN.
- Defined:
  - A free-running blink ms counter toggles a phase bit every BLINK_MS ticks; counter and phase reset to 0.
  - While alarm = 1 and phase = 1, d0..d3 <= 7'b1111111 regardless of state. owner, b_ack, b_done and all state timing are unaffected.
  - alarm = 0 restores the normal d* on the next edge.
- Undefined: alarm is ignored; no blink logic is synthesised; d* are never forced blank after reset.

Test Plan:
- Bench parameters: TICK_DIV=4, HOLD_MS=3, GUARD_MS=2, BLINK_MS=2.
- Reset then a_d0=7'h40 with b_req=0 → d* = 7'h7F during reset, d0 = 7'h40 one cycle after release, owner=0, b_ack=0 throughout.
- b_req=1 at cycle 10 with b_d0=7'h06 → b_ack pulses at cycle 11 only; owner=1 and d0=7'h06 for cycles 12..23; b_done pulses at cycle 24, where owner=0 and d0 follows a_d0.
- b_req held high through a grant, then re-requested → no second b_ack during cycles 24..31 (GUARD, 8 cycles); second b_ack exactly at cycle 33.
- b_d0 toggled during SHOW_B, b_req dropped mid-hold → d0 stays at the latched value; hold still lasts 12 cycles with a single b_done.
- reset pulsed mid-SHOW_B → owner=0, d* = 7'h7F, b_done never pulses; the next b_req is granted normally.
- With DISP_ALARM_BLINK_EN and alarm=1 → d* alternate blank/normal every 8 cycles; state timing is identical to the non-alarm case. Without the macro, d* are never blanked.
